issue_rs_age: RTL and testbench
===============================

// Module: issue_rs_age
// PURPOSE
// Generalised single-issue reservation station: parametrised depth, opaque payload width and N wakeup ports.
// Picks the oldest ready entry via an age matrix, not by lowest index.
// Tracks per-entry operand readiness from writeback tag broadcasts; the busytable is read only at push.
// Issue output is a registered valid/pop handshake. Sits between rename/dispatch and one EX pipe.
// PARAMETERS
// CONFIG_P_RS_DEPTH   3   log2 of entry count (RS_DEPTH = 1<<P); >=1
// CONFIG_PAYLOAD_W    64  opaque payload bits per entry (opcode, imm, pc, prd, rob id ...)
// CONFIG_NUM_WAKEUP   2   number of writeback tag broadcast ports; >=1
// PORTS
// clk               in   1                    clock, all state on rising edge
// rst_n             in   1                    asynchronous active-low reset
// flush             in   1                    discard all entries and the output slot
// issue_push        in   1                    write one entry; ignored when issue_rs_full
// issue_prs1        in   `NCPU_PRF_AW          source 1 physical tag
// issue_prs1_re     in   1                    source 1 used
// issue_prs2        in   `NCPU_PRF_AW          source 2 physical tag
// issue_prs2_re     in   1                    source 2 used
// issue_payload     in   CONFIG_PAYLOAD_W     opaque payload
// issue_rs_full     out  1                    all entries valid (registered state only)
// rs_count          out  P+1                  number of valid entries
// busytable         in   1<<`NCPU_PRF_AW       1 = tag not yet written back
// wb_wake_valid     in   NUM_WAKEUP           per-port broadcast valid
// wb_wake_prd       in   NUM_WAKEUP*`NCPU_PRF_AW broadcast tags, port k at [k*AW +: AW]
// ro_valid          out  1                    output slot holds an instruction
// ro_rs_pop         in   1                    consumer accepts output slot this cycle
// ro_payload        out  CONFIG_PAYLOAD_W     payload of issued entry
// ro_prs1/ro_prs2   out  `NCPU_PRF_AW each     issued source tags
// ro_prs1_re/_re2   out  1 each               issued source enables (ro_prs1_re, ro_prs2_re)
// BEHAVIOUR
// - Reset (rst_n=0, async): all entries invalid, age matrix 0, ro_valid=0, ro_* data 0, rs_count=0, full=0.
// - Entry state: vld, prs1/2, re1/2, rdy1/2, payload. rdyX = ~reX | ~busytable[prsX] | any wake match (valid & tag==prsX) at push.
// - Push: lowest-index invalid entry (from registered vld) written at edge; an entry freed this same cycle is not reused until next.
// - Wakeup: any valid port whose tag equals a valid entry's prsX sets rdyX next edge; a port may match many entries.
// - Eligible[i] = vld & rdy1 & rdy2. Age: row of newly pushed k cleared, column k set (all residents older).
// - Select oldest eligible: i with no eligible j where age[j][i]=1. Unique by construction.
// - Output slot loads when (~ro_valid | ro_rs_pop) & any eligible; selected entry's vld cleared same edge.
// - ro_valid drops after pop only when nothing eligible; data held stable while ro_valid & ~ro_rs_pop.
// - Latency: push at t with both sources ready -> ro_valid at t+2. Wakeup at t -> eligible t+1 -> ro_valid t+2.
// - Back-to-back: pop every cycle with eligible entries -> one issue per cycle, no bubble.
// - Push+select same cycle: rs_count += 0; push only: +1; select only: -1.
// - flush: dominates push/wakeup/select; next edge all vld=0, age=0, ro_valid=0. Pop ignored under flush.
// - Push while full: dropped, no state change (bench asserts this never happens).
// - ro_rs_pop while ~ro_valid: no effect.
// STRUCTURE
// - Tags/widths from ncpu64k_config.vh (`NCPU_PRF_AW); no new typedefs; RS_DEPTH localparam local.
// - Sub-module rs_age_matrix: RS_DEPTH x RS_DEPTH age bits, push/clear/flush inputs,
//   eligible vector in, one-hot oldest + gs out. Reused by the LSU queue.
// - Free pick via priority_encoder_gs; state flops use async active-low reset flops.
// TESTING
// - Reset then 3 pushes with ready sources, pop held 1 -> issue order entry0,1,2, ro_valid t+2, rs_count 3->0.
// - Push A (prs1=5 busy), then B ready -> B issues first; wake tag 5 at t -> A issues at t+2.
// - Fill 8 entries -> issue_rs_full=1; pop one with push same cycle -> count stays 8, full reasserts.
// - Hold ro_rs_pop=0 for 4 cycles -> ro_payload/ro_prs* unchanged, no entry vld cleared.
// - Two wake ports hit same tag 9 on 3 entries -> all three eligible next cycle, issued oldest-first.
// - flush with 5 entries and ro_valid=1 -> next cycle ro_valid=0, rs_count=0, full=0; async rst_n mid-burst same.

Source files
------------

// File: rtl/issue_rs_age_pkg.sv
// Shared widths for the age-ordered reservation station.
package issue_rs_age_pkg;

    // Physical register tag width and the matching busytable size.
    localparam int unsigned NCPU_PRF_AW = 6;
    localparam int unsigned NCPU_PRF_N  = 1 << NCPU_PRF_AW;

    // True when a broadcast is valid and carries the tag being watched.
    function automatic logic tag_hit(input logic                   valid,
                                     input logic [NCPU_PRF_AW-1:0] bcast,
                                     input logic [NCPU_PRF_AW-1:0] tag);
        return valid && (bcast == tag);
    endfunction

endpackage

// File: rtl/issue_rs_age_matrix.sv
// Age matrix: age[j][i] = 1 means entry j is older than entry i.
// Picks the single oldest entry among an eligible vector.
module issue_rs_age_matrix #(
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [DEPTH-1:0] push_oh,
    input  logic [DEPTH-1:0] clear,
    input  logic [DEPTH-1:0] eligible,
    output logic [DEPTH-1:0] oldest,
    output logic             gs
);

    logic [DEPTH-1:0][DEPTH-1:0] age_q, age_d;

    // Next age state: retired rows cleared, a new entry is younger than everyone.
    always_comb begin
        age_d = age_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (clear[i]) age_d[i] = '0;
        end
        if (push) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (push_oh[k]) begin
                    age_d[k] = '0;
                    for (int j = 0; j < DEPTH; j++) begin
                        if (j != k) age_d[j][k] = 1'b1;
                    end
                end
            end
        end
        if (flush) age_d = '0;
    end

    // Age bit storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) age_q <= '0;
        else        age_q <= age_d;
    end

    // An eligible entry wins if no other eligible entry is older than it.
    always_comb begin
        oldest = '0;
        for (int i = 0; i < DEPTH; i++) begin
            logic blocked;
            blocked = 1'b0;
            for (int j = 0; j < DEPTH; j++) begin
                if (eligible[j] && age_q[j][i]) blocked = 1'b1;
            end
            oldest[i] = eligible[i] && !blocked;
        end
        gs = |eligible;
    end

endmodule

// File: rtl/issue_rs_age.sv
// Single-issue reservation station with age-ordered select and tag wakeup.
module issue_rs_age
    import issue_rs_age_pkg::*;
#(
    parameter int unsigned CONFIG_P_RS_DEPTH = 3,
    parameter int unsigned CONFIG_PAYLOAD_W  = 64,
    parameter int unsigned CONFIG_NUM_WAKEUP = 2
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     flush,
    input  logic                                     issue_push,
    input  logic [NCPU_PRF_AW-1:0]                   issue_prs1,
    input  logic                                     issue_prs1_re,
    input  logic [NCPU_PRF_AW-1:0]                   issue_prs2,
    input  logic                                     issue_prs2_re,
    input  logic [CONFIG_PAYLOAD_W-1:0]              issue_payload,
    output logic                                     issue_rs_full,
    output logic [CONFIG_P_RS_DEPTH:0]               rs_count,
    input  logic [NCPU_PRF_N-1:0]                    busytable,
    input  logic [CONFIG_NUM_WAKEUP-1:0]             wb_wake_valid,
    input  logic [CONFIG_NUM_WAKEUP*NCPU_PRF_AW-1:0] wb_wake_prd,
    output logic                                     ro_valid,
    input  logic                                     ro_rs_pop,
    output logic [CONFIG_PAYLOAD_W-1:0]              ro_payload,
    output logic [NCPU_PRF_AW-1:0]                   ro_prs1,
    output logic [NCPU_PRF_AW-1:0]                   ro_prs2,
    output logic                                     ro_prs1_re,
    output logic                                     ro_prs2_re
);

    localparam int unsigned RS_DEPTH = 1 << CONFIG_P_RS_DEPTH;
    localparam int unsigned AW       = NCPU_PRF_AW;
    localparam int unsigned PW       = CONFIG_PAYLOAD_W;

    logic [RS_DEPTH-1:0] vld_q, re1_q, re2_q, rdy1_q, rdy2_q;
    logic [AW-1:0]       prs1_q [RS_DEPTH];
    logic [AW-1:0]       prs2_q [RS_DEPTH];
    logic [PW-1:0]       payload_q [RS_DEPTH];

    logic                ro_valid_q, ro_prs1_re_q, ro_prs2_re_q;
    logic [AW-1:0]       ro_prs1_q, ro_prs2_q;
    logic [PW-1:0]       ro_payload_q;

    logic [RS_DEPTH-1:0] free_oh, eligible, oldest, hit1, hit2;
    logic                any_free, any_elig, push_en, sel_en;
    logic                push_hit1, push_hit2, push_rdy1, push_rdy2;
    logic [PW-1:0]       sel_payload;
    logic [AW-1:0]       sel_prs1, sel_prs2;
    logic                sel_re1, sel_re2;
    logic [CONFIG_P_RS_DEPTH:0] count;

    assign issue_rs_full = &vld_q;
    assign push_en       = issue_push && !issue_rs_full && !flush;
    assign eligible      = vld_q & rdy1_q & rdy2_q;
    assign sel_en        = (!ro_valid_q || ro_rs_pop) && any_elig && !flush;

    // Lowest-index free slot from registered valid bits only.
    always_comb begin
        free_oh  = '0;
        any_free = 1'b0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (!vld_q[i] && !any_free) begin
                free_oh[i] = 1'b1;
                any_free   = 1'b1;
            end
        end
    end

    // Wakeup matches against resident entries and against the entry being pushed.
    always_comb begin
        hit1      = '0;
        hit2      = '0;
        push_hit1 = 1'b0;
        push_hit2 = 1'b0;
        for (int k = 0; k < CONFIG_NUM_WAKEUP; k++) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (tag_hit(wb_wake_valid[k], wb_wake_prd[k*AW +: AW], prs1_q[i])) hit1[i] = 1'b1;
                if (tag_hit(wb_wake_valid[k], wb_wake_prd[k*AW +: AW], prs2_q[i])) hit2[i] = 1'b1;
            end
            if (tag_hit(wb_wake_valid[k], wb_wake_prd[k*AW +: AW], issue_prs1)) push_hit1 = 1'b1;
            if (tag_hit(wb_wake_valid[k], wb_wake_prd[k*AW +: AW], issue_prs2)) push_hit2 = 1'b1;
        end
        push_rdy1 = !issue_prs1_re || !busytable[issue_prs1] || push_hit1;
        push_rdy2 = !issue_prs2_re || !busytable[issue_prs2] || push_hit2;
    end

    issue_rs_age_matrix #(
        .DEPTH    (RS_DEPTH)
    ) u_age (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .push     (push_en),
        .push_oh  (free_oh),
        .clear    (sel_en ? oldest : '0),
        .eligible (eligible),
        .oldest   (oldest),
        .gs       (any_elig)
    );

    // One-hot mux of the selected entry; also counts valid entries.
    always_comb begin
        sel_payload = '0;
        sel_prs1    = '0;
        sel_prs2    = '0;
        sel_re1     = 1'b0;
        sel_re2     = 1'b0;
        count       = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (oldest[i]) begin
                sel_payload = sel_payload | payload_q[i];
                sel_prs1    = sel_prs1 | prs1_q[i];
                sel_prs2    = sel_prs2 | prs2_q[i];
                sel_re1     = sel_re1 | re1_q[i];
                sel_re2     = sel_re2 | re2_q[i];
            end
            count = count + {{CONFIG_P_RS_DEPTH{1'b0}}, vld_q[i]};
        end
    end

    assign rs_count = count;

    // Entry array: flush, then retire the selected entry, then write the pushed one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= '0;
            re1_q  <= '0;
            re2_q  <= '0;
            rdy1_q <= '0;
            rdy2_q <= '0;
            for (int i = 0; i < RS_DEPTH; i++) begin
                prs1_q[i]    <= '0;
                prs2_q[i]    <= '0;
                payload_q[i] <= '0;
            end
        end else if (flush) begin
            vld_q <= '0;
        end else begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (push_en && free_oh[i]) begin
                    vld_q[i]     <= 1'b1;
                    prs1_q[i]    <= issue_prs1;
                    prs2_q[i]    <= issue_prs2;
                    re1_q[i]     <= issue_prs1_re;
                    re2_q[i]     <= issue_prs2_re;
                    rdy1_q[i]    <= push_rdy1;
                    rdy2_q[i]    <= push_rdy2;
                    payload_q[i] <= issue_payload;
                end else begin
                    if (sel_en && oldest[i]) vld_q[i] <= 1'b0;
                    if (vld_q[i] && hit1[i]) rdy1_q[i] <= 1'b1;
                    if (vld_q[i] && hit2[i]) rdy2_q[i] <= 1'b1;
                end
            end
        end
    end

    // Output slot: load on select, drop after pop when nothing is eligible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ro_valid_q   <= 1'b0;
            ro_payload_q <= '0;
            ro_prs1_q    <= '0;
            ro_prs2_q    <= '0;
            ro_prs1_re_q <= 1'b0;
            ro_prs2_re_q <= 1'b0;
        end else if (flush) begin
            ro_valid_q <= 1'b0;
        end else if (sel_en) begin
            ro_valid_q   <= 1'b1;
            ro_payload_q <= sel_payload;
            ro_prs1_q    <= sel_prs1;
            ro_prs2_q    <= sel_prs2;
            ro_prs1_re_q <= sel_re1;
            ro_prs2_re_q <= sel_re2;
        end else if (ro_rs_pop) begin
            ro_valid_q <= 1'b0;
        end
    end

    assign ro_valid   = ro_valid_q;
    assign ro_payload = ro_payload_q;
    assign ro_prs1    = ro_prs1_q;
    assign ro_prs2    = ro_prs2_q;
    assign ro_prs1_re = ro_prs1_re_q;
    assign ro_prs2_re = ro_prs2_re_q;

endmodule

// File: tb/tb_issue_rs_age.sv
// Directed bench for issue_rs_age: ordering, wakeup, full, hold, flush, async reset.
module tb_issue_rs_age;
    import issue_rs_age_pkg::*;

    localparam int unsigned P  = 3;
    localparam int unsigned PW = 64;
    localparam int unsigned NW = 2;
    localparam int unsigned AW = NCPU_PRF_AW;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 flush;
    logic                 issue_push;
    logic [AW-1:0]        issue_prs1, issue_prs2;
    logic                 issue_prs1_re, issue_prs2_re;
    logic [PW-1:0]        issue_payload;
    logic                 issue_rs_full;
    logic [P:0]           rs_count;
    logic [NCPU_PRF_N-1:0] busytable;
    logic [NW-1:0]        wb_wake_valid;
    logic [NW*AW-1:0]     wb_wake_prd;
    logic                 ro_valid, ro_rs_pop;
    logic [PW-1:0]        ro_payload;
    logic [AW-1:0]        ro_prs1, ro_prs2;
    logic                 ro_prs1_re, ro_prs2_re;

    int tests = 0;
    int fails = 0;

    issue_rs_age #(
        .CONFIG_P_RS_DEPTH (P),
        .CONFIG_PAYLOAD_W  (PW),
        .CONFIG_NUM_WAKEUP (NW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .issue_push    (issue_push),
        .issue_prs1    (issue_prs1),
        .issue_prs1_re (issue_prs1_re),
        .issue_prs2    (issue_prs2),
        .issue_prs2_re (issue_prs2_re),
        .issue_payload (issue_payload),
        .issue_rs_full (issue_rs_full),
        .rs_count      (rs_count),
        .busytable     (busytable),
        .wb_wake_valid (wb_wake_valid),
        .wb_wake_prd   (wb_wake_prd),
        .ro_valid      (ro_valid),
        .ro_rs_pop     (ro_rs_pop),
        .ro_payload    (ro_payload),
        .ro_prs1       (ro_prs1),
        .ro_prs2       (ro_prs2),
        .ro_prs1_re    (ro_prs1_re),
        .ro_prs2_re    (ro_prs2_re)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle, inputs change right after.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [AW-1:0] p1, input logic r1, input logic [AW-1:0] p2,
                        input logic r2, input logic [PW-1:0] pl);
        issue_push    = 1'b1;
        issue_prs1    = p1;
        issue_prs1_re = r1;
        issue_prs2    = p2;
        issue_prs2_re = r2;
        issue_payload = pl;
    endtask

    task automatic no_push();
        issue_push = 1'b0;
    endtask

    task automatic wake(input logic v0, input logic [AW-1:0] t0,
                        input logic v1, input logic [AW-1:0] t1);
        wb_wake_valid = {v1, v0};
        wb_wake_prd   = {t1, t0};
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        issue_push = 1'b0;
        issue_prs1 = '0;
        issue_prs2 = '0;
        issue_prs1_re = 1'b0;
        issue_prs2_re = 1'b0;
        issue_payload = '0;
        busytable = '0;
        wb_wake_valid = '0;
        wb_wake_prd = '0;
        ro_rs_pop = 1'b0;
        #12;
        chk("rst_ro_valid", {63'd0, ro_valid}, 64'd0);
        chk("rst_count", {60'd0, rs_count}, 64'd0);
        chk("rst_full", {63'd0, issue_rs_full}, 64'd0);
        chk("rst_payload", ro_payload, 64'd0);
        rst_n = 1'b1;
        step();

        // In-order issue of three ready pushes with pop held high.
        ro_rs_pop = 1'b1;
        push(6'd1, 1'b1, 6'd2, 1'b1, 64'h100);
        step();
        chk("t1_count_e1", {60'd0, rs_count}, 64'd1);
        chk("t1_valid_e1", {63'd0, ro_valid}, 64'd0);
        push(6'd1, 1'b1, 6'd2, 1'b1, 64'h101);
        step();
        chk("t1_valid_e2", {63'd0, ro_valid}, 64'd1);
        chk("t1_pl0", ro_payload, 64'h100);
        chk("t1_count_e2", {60'd0, rs_count}, 64'd1);
        push(6'd1, 1'b1, 6'd2, 1'b1, 64'h102);
        step();
        chk("t1_pl1", ro_payload, 64'h101);
        no_push();
        step();
        chk("t1_pl2", ro_payload, 64'h102);
        chk("t1_count_end", {60'd0, rs_count}, 64'd0);
        step();
        chk("t1_drain", {63'd0, ro_valid}, 64'd0);

        // Older A waits on tag 5, younger ready B issues first.
        busytable[5] = 1'b1;
        push(6'd5, 1'b1, 6'd0, 1'b0, 64'hAA);
        step();
        push(6'd3, 1'b1, 6'd0, 1'b0, 64'hBB);
        step();
        no_push();
        chk("t2_count", {60'd0, rs_count}, 64'd2);
        step();
        chk("t2_b_first", ro_payload, 64'hBB);
        chk("t2_b_valid", {63'd0, ro_valid}, 64'd1);
        wake(1'b1, 6'd5, 1'b0, 6'd0);
        step();
        wake(1'b0, 6'd0, 1'b0, 6'd0);
        chk("t2_wake_t1", {63'd0, ro_valid}, 64'd0);
        step();
        chk("t2_wake_t2", {63'd0, ro_valid}, 64'd1);
        chk("t2_a_pl", ro_payload, 64'hAA);
        chk("t2_a_prs1", {58'd0, ro_prs1}, 64'd5);
        step();
        chk("t2_empty", {60'd0, rs_count}, 64'd0);
        busytable = '0;

        // Fill with entries blocked on tags 10..17.
        ro_rs_pop = 1'b0;
        for (int i = 0; i < 8; i++) begin
            busytable[10+i] = 1'b1;
            push(6'(10 + i), 1'b1, 6'd0, 1'b0, 64'h300 + 64'(i));
            step();
            if (i == 6) chk("t3_not_full7", {63'd0, issue_rs_full}, 64'd0);
        end
        no_push();
        chk("t3_full", {63'd0, issue_rs_full}, 64'd1);
        chk("t3_count8", {60'd0, rs_count}, 64'd8);
        wake(1'b1, 6'd10, 1'b0, 6'd0);
        step();
        wake(1'b0, 6'd0, 1'b0, 6'd0);
        step();
        chk("t3_sel0", ro_payload, 64'h300);
        chk("t3_count7", {60'd0, rs_count}, 64'd7);
        chk("t3_full_drop", {63'd0, issue_rs_full}, 64'd0);
        busytable[20] = 1'b1;
        push(6'd20, 1'b1, 6'd0, 1'b0, 64'h308);
        step();
        no_push();
        chk("t3_full_again", {63'd0, issue_rs_full}, 64'd1);
        wake(1'b1, 6'd11, 1'b0, 6'd0);
        step();
        wake(1'b0, 6'd0, 1'b0, 6'd0);

        // Output slot must hold while not popped.
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t4_hold_pl", ro_payload, 64'h300);
            chk("t4_hold_prs1", {58'd0, ro_prs1}, 64'd10);
            chk("t4_hold_cnt", {60'd0, rs_count}, 64'd8);
        end
        ro_rs_pop = 1'b1;
        wake(1'b1, 6'd12, 1'b0, 6'd0);
        step();
        chk("t4_pop_sel1", ro_payload, 64'h301);
        chk("t4_pop_cnt", {60'd0, rs_count}, 64'd7);
        wake(1'b0, 6'd0, 1'b0, 6'd0);
        busytable[21] = 1'b1;
        push(6'd21, 1'b1, 6'd0, 1'b0, 64'h309);
        step();
        no_push();
        chk("t4_push_sel_pl", ro_payload, 64'h302);
        chk("t4_push_sel_cnt", {60'd0, rs_count}, 64'd7);

        // Flush with entries resident and output slot occupied.
        chk("t5_pre_valid", {63'd0, ro_valid}, 64'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("t5_flush_valid", {63'd0, ro_valid}, 64'd0);
        chk("t5_flush_cnt", {60'd0, rs_count}, 64'd0);
        chk("t5_flush_full", {63'd0, issue_rs_full}, 64'd0);
        busytable = '0;

        // Both wake ports broadcast tag 9 to three waiting entries.
        busytable[9] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push(6'd0, 1'b0, 6'd9, 1'b1, 64'h900 + 64'(i));
            step();
        end
        no_push();
        chk("t6_cnt3", {60'd0, rs_count}, 64'd3);
        chk("t6_idle", {63'd0, ro_valid}, 64'd0);
        wake(1'b1, 6'd9, 1'b1, 6'd9);
        step();
        wake(1'b0, 6'd0, 1'b0, 6'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t6_order", ro_payload, 64'h900 + 64'(i));
            chk("t6_prs2", {57'd0, ro_prs2_re, ro_prs2}, 64'h49);
        end
        chk("t6_cnt0", {60'd0, rs_count}, 64'd0);
        busytable = '0;
        step();

        // Asynchronous reset in the middle of a burst.
        ro_rs_pop = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push(6'd1, 1'b1, 6'd1, 1'b1, 64'hD00 + 64'(i));
            step();
        end
        no_push();
        chk("t7_pre_cnt", {60'd0, rs_count}, 64'd2);
        chk("t7_pre_pl", ro_payload, 64'hD00);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t7_rst_valid", {63'd0, ro_valid}, 64'd0);
        chk("t7_rst_cnt", {60'd0, rs_count}, 64'd0);
        chk("t7_rst_pl", ro_payload, 64'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("t7_post_cnt", {60'd0, rs_count}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
